pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/redirect controller for the 8-bit PC register. Drives the PC's PC_in
//  (advance/hold), LOAD and PC_val ports, fetches opcode and operand bytes from instruction memory,
//  and hands non-branch opcodes to the execute unit. Resolves JMP/JZ, stops on HALT.
// PARAMETERS
//  AW       8      address/PC width; PC wraps modulo 2^AW
//  HALT_OP  8'h3F  opcode that enters S_HALT
// PORTS
//  CLK        in   1   system clock, rising edge
//  RESET      in   1   asynchronous, active-low reset
//  PC_cur     in   AW  current PC (PC_out of the PC block)
//  PC_next    out  AW  to PC_in; PC samples it every CLK
//  PC_load    out  1   to LOAD; 1-cycle registered pulse
//  PC_target  out  AW  to PC_val; redirect address
//  MEM_req    out  1   instruction read request, address = MEM_addr
//  MEM_addr   out  AW  read address (always PC_cur)
//  MEM_rdata  in   8   read data, valid when MEM_ready=1
//  MEM_ready  in   1   read completes this cycle
//  IR         out  8   latched opcode
//  EXEC_start out  1   1-cycle pulse: execute IR
//  EXEC_done  in   1   execute unit finished
//  FLAG_Z     in   1   zero flag, sampled in S_DECODE of JZ
//  HALTED     out  1   high while in S_HALT
// BEHAVIOUR
//  Reset (RESET=0, async): state=S_FETCH, IR=0, PC_target=0, PC_load=0, EXEC_start=0, HALTED=0.
//   Reset mid-operation aborts any pending read/exec; no residual pulses after release.
//  Decode: IR[7:5]=3'b110 JMP, 3'b111 JZ (both 2-byte: operand = target); IR==HALT_OP halt;
//   all other opcodes execute-class (1 byte).
//  PC_next = PC_cur + 1 (mod 2^AW) in any cycle where MEM_req & MEM_ready; else PC_cur.
//   In S_REDIR and S_SETTLE PC_next = PC_target (no advance).
//  States:
//   S_FETCH : MEM_req=1. On MEM_ready: IR<=MEM_rdata, PC advances, -> S_DECODE. Zero-wait ok.
//   S_DECODE: HALT_OP -> S_HALT; JMP/JZ -> S_OPND; else EXEC_start=1 -> S_EXEC.
//   S_OPND  : MEM_req=1. On MEM_ready: PC advances; if JMP, or JZ with FLAG_Z latched =1:
//             PC_target<=MEM_rdata, PC_load<=1 -> S_REDIR; else -> S_FETCH (fall-through).
//   S_EXEC  : wait; EXEC_done sampled from the cycle after EXEC_start; on 1 -> S_FETCH.
//   S_REDIR : PC_load=1 (exactly one cycle) -> S_SETTLE.
//   S_SETTLE: PC_load=0, PC_target and PC_next held = target (PC load path is registered and
//             re-samples PC_val one extra edge) -> S_FETCH.
//   S_HALT  : HALTED=1, MEM_req=0, PC_next=PC_cur; exits only by reset.
//  FLAG_Z latched in S_DECODE for JZ; later changes ignored.
//  Latency: exec op = 3 cycles + exec time; taken branch = 5 cycles (zero-wait memory);
//   not-taken JZ = 3 cycles.
//  Wrap: PC_cur=FF fetch -> PC_next=00; operand at FF wraps to 00 identically.
//  MEM_ready outside S_FETCH/S_OPND ignored; EXEC_done outside S_EXEC ignored.
// STRUCTURE
//  Package pc_seq_pkg: state encoding (7 states, 3-bit), OPC_JMP=3'b110, OPC_JZ=3'b111, default HALT_OP.
//  Sub-module instr_class_dec (combinational): IR -> {is_jmp, is_jz, is_halt, is_exec}.
//  Registered FSM + registered PC_load/PC_target/EXEC_start; PC_next combinational.
// TESTING
//  1 Reset at PC=00, mem {00:05} zero-wait, EXEC_done 2 cycles after start -> IR=05, EXEC_start
//    one pulse, PC_cur=01, back in S_FETCH.
//  2 mem {10:C0,11:40} -> PC_load one cycle, PC_target=40 held 2 cycles, PC_cur=40 after settle.
//  3 JZ {20:E0,21:80}: FLAG_Z=0 -> PC_cur=22, no PC_load; FLAG_Z=1 -> PC_cur=80.
//  4 PC=FF, mem {FF:C0,00:07} -> operand read at 00, PC_cur=07.
//  5 MEM_ready delayed 3 cycles -> MEM_req held, PC_next=PC_cur until ready, single advance.
//  6 HALT_OP at 30 -> HALTED=1, MEM_req=0 stays; RESET low mid-S_EXEC -> outputs at reset values.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared encodings for the PC fetch/decode/redirect sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_OPND   = 3'd2,
        S_EXEC   = 3'd3,
        S_REDIR  = 3'd4,
        S_SETTLE = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [2:0] OPC_JMP     = 3'b110;
    localparam logic [2:0] OPC_JZ      = 3'b111;
    localparam logic [7:0] HALT_OP_DEF = 8'h3F;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// PC / instruction-memory / execute-unit bundle seen by the fetch sequencer.
interface pc_fetch_sequencer_if #(parameter int AW = 8);

    logic [AW-1:0] PC_cur;
    logic [AW-1:0] PC_next;
    logic          PC_load;
    logic [AW-1:0] PC_target;
    logic          MEM_req;
    logic [AW-1:0] MEM_addr;
    logic [7:0]    MEM_rdata;
    logic          MEM_ready;
    logic [7:0]    IR;
    logic          EXEC_start;
    logic          EXEC_done;
    logic          FLAG_Z;
    logic          HALTED;

    modport master (
        input  PC_cur, MEM_rdata, MEM_ready, EXEC_done, FLAG_Z,
        output PC_next, PC_load, PC_target, MEM_req, MEM_addr, IR, EXEC_start, HALTED
    );

    modport slave (
        output PC_cur, MEM_rdata, MEM_ready, EXEC_done, FLAG_Z,
        input  PC_next, PC_load, PC_target, MEM_req, MEM_addr, IR, EXEC_start, HALTED
    );

endinterface

// File: rtl/pc_fetch_sequencer_dec.sv
// Opcode classifier: HALT wins over the branch classes so HALT_OP may sit anywhere.
module instr_class_dec
    import pc_seq_pkg::*;
#(
    parameter logic [7:0] HALT_OP = HALT_OP_DEF
) (
    input  logic [7:0] ir_i,
    output logic       is_jmp_o,
    output logic       is_jz_o,
    output logic       is_halt_o,
    output logic       is_exec_o
);

    always_comb begin
        is_halt_o = (ir_i == HALT_OP);
        is_jmp_o  = !is_halt_o && (ir_i[7:5] == OPC_JMP);
        is_jz_o   = !is_halt_o && (ir_i[7:5] == OPC_JZ);
        is_exec_o = !(is_halt_o || is_jmp_o || is_jz_o);
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/decode/redirect controller driving the PC register, instruction memory and execute unit.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int         AW      = 8,
    parameter logic [7:0] HALT_OP = HALT_OP_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    pc_fetch_sequencer_if.master bus
);

    state_e        state_q, state_d;
    logic [7:0]    ir_q, ir_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic          load_q, load_d;
    logic          start_q, start_d;
    logic          z_q, z_d;
    logic          mem_req;
    logic          is_jmp, is_jz, is_halt, is_exec;

    instr_class_dec #(.HALT_OP(HALT_OP)) u_dec (
        .ir_i      (ir_q),
        .is_jmp_o  (is_jmp),
        .is_jz_o   (is_jz),
        .is_halt_o (is_halt),
        .is_exec_o (is_exec)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            tgt_q   <= '0;
            load_q  <= 1'b0;
            start_q <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            tgt_q   <= tgt_d;
            load_q  <= load_d;
            start_q <= start_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        tgt_d   = tgt_q;
        load_d  = 1'b0;
        start_d = 1'b0;
        z_d     = z_q;
        mem_req = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.MEM_ready) begin
                    ir_d    = bus.MEM_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_jmp || is_jz) begin
                    z_d     = bus.FLAG_Z;
                    state_d = S_OPND;
                end else if (is_exec) begin
                    start_d = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_OPND: begin
                mem_req = 1'b1;
                if (bus.MEM_ready) begin
                    if (is_jmp || (is_jz && z_q)) begin
                        tgt_d   = AW'(bus.MEM_rdata);
                        load_d  = 1'b1;
                        state_d = S_REDIR;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            // EXEC_done is only trusted once the start pulse has been seen by the unit
            S_EXEC:   if (!start_q && bus.EXEC_done) state_d = S_FETCH;
            S_REDIR:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // The PC load path re-samples PC_val one edge late, so the target is also fed on PC_in
    always_comb begin
        if (state_q == S_REDIR || state_q == S_SETTLE)
            bus.PC_next = tgt_q;
        else if (mem_req && bus.MEM_ready)
            bus.PC_next = bus.PC_cur + AW'(1);
        else
            bus.PC_next = bus.PC_cur;
    end

    assign bus.MEM_req    = mem_req;
    assign bus.MEM_addr   = bus.PC_cur;
    assign bus.PC_load    = load_q;
    assign bus.PC_target  = tgt_q;
    assign bus.IR         = ir_q;
    assign bus.EXEC_start = start_q;
    assign bus.HALTED     = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench: instruction-level model expands each opcode into its expected cycle script.
module tb_pc_fetch_sequencer;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    pc_fetch_sequencer_if #(.AW(8)) bus();

    pc_fetch_sequencer #(.AW(8), .HALT_OP(8'h3F)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rdy, done, fz;
        logic       req, load, start, halted;
        logic [7:0] addr, nxt, tgt, ir;
    } row_t;

    row_t       rows[$];
    logic [7:0] mem [256];
    logic [7:0] pc;
    logic [7:0] m_pc, m_ir, m_tgt;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic push(input logic rdy, input logic done, input logic fz, input logic req,
                        input logic [7:0] nxt, input logic load, input logic start,
                        input logic halted);
        row_t r;
        r.rdy = rdy; r.done = done; r.fz = fz; r.req = req;
        r.load = load; r.start = start; r.halted = halted;
        r.addr = m_pc; r.nxt = nxt; r.tgt = m_tgt; r.ir = m_ir;
        rows.push_back(r);
    endtask

    // Expands n instructions from start into per-cycle expectations.
    // fw: fixed memory wait (-1 random); fzf: forced FLAG_Z at decode (-1 random);
    // ed: execute busy cycles before done (-1 random).
    task automatic gen(input logic [7:0] start, input int n, input int fw, input int fzf,
                       input int ed);
        logic [7:0] t;
        logic       f;
        int         w;
        rows.delete();
        m_pc = start; m_ir = 8'h00; m_tgt = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = (fw >= 0) ? fw : int'($urandom_range(0, 3));
            for (int j = 0; j < w; j++) push(1'b0, rb(), rb(), 1'b1, m_pc, 1'b0, 1'b0, 1'b0);
            push(1'b1, rb(), rb(), 1'b1, m_pc + 8'd1, 1'b0, 1'b0, 1'b0);
            m_ir = mem[m_pc];
            m_pc = m_pc + 8'd1;
            f = (fzf >= 0) ? 1'(fzf) : rb();
            push(rb(), rb(), f, 1'b0, m_pc, 1'b0, 1'b0, 1'b0);
            if (m_ir == 8'h3F) begin
                for (int j = 0; j < 4; j++) push(rb(), rb(), rb(), 1'b0, m_pc, 1'b0, 1'b0, 1'b1);
                return;
            end else if (m_ir[7:6] == 2'b11) begin
                w = (fw >= 0) ? fw : int'($urandom_range(0, 3));
                for (int j = 0; j < w; j++) push(1'b0, rb(), rb(), 1'b1, m_pc, 1'b0, 1'b0, 1'b0);
                push(1'b1, rb(), rb(), 1'b1, m_pc + 8'd1, 1'b0, 1'b0, 1'b0);
                t = mem[m_pc];
                m_pc = m_pc + 8'd1;
                if (m_ir[5] == 1'b0 || f) begin
                    m_tgt = t;
                    push(rb(), rb(), rb(), 1'b0, t, 1'b1, 1'b0, 1'b0);
                    m_pc = t;
                    push(rb(), rb(), rb(), 1'b0, t, 1'b0, 1'b0, 1'b0);
                end
            end else begin
                push(rb(), rb(), rb(), 1'b0, m_pc, 1'b0, 1'b1, 1'b0);
                w = (ed >= 0) ? ed : int'($urandom_range(0, 3));
                for (int j = 0; j < w; j++) push(rb(), 1'b0, rb(), 1'b0, m_pc, 1'b0, 1'b0, 1'b0);
                push(rb(), 1'b1, rb(), 1'b0, m_pc, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    // Plays the script: drives inputs, checks every output each cycle, and acts as the PC register.
    task automatic run_rows(input int limit);
        row_t       r;
        logic [7:0] pn;
        for (int k = 0; k < rows.size() && k < limit; k++) begin
            r = rows[k];
            bus.PC_cur    = pc;
            bus.MEM_ready = r.rdy;
            bus.EXEC_done = r.done;
            bus.FLAG_Z    = r.fz;
            bus.MEM_rdata = r.rdy ? mem[pc] : 8'($urandom);
            @(negedge CLK);
            chk($sformatf("c%0d_req", k),    bus.MEM_req,    r.req);
            chk($sformatf("c%0d_addr", k),   bus.MEM_addr,   r.addr);
            chk($sformatf("c%0d_next", k),   bus.PC_next,    r.nxt);
            chk($sformatf("c%0d_load", k),   bus.PC_load,    r.load);
            chk($sformatf("c%0d_tgt", k),    bus.PC_target,  r.tgt);
            chk($sformatf("c%0d_start", k),  bus.EXEC_start, r.start);
            chk($sformatf("c%0d_ir", k),     bus.IR,         r.ir);
            chk($sformatf("c%0d_halted", k), bus.HALTED,     r.halted);
            pn = bus.PC_load ? bus.PC_target : bus.PC_next;
            @(posedge CLK);
            #1;
            pc = pn;
        end
    endtask

    task automatic do_reset(input logic [7:0] pc0);
        RESET = 1'b0;
        bus.MEM_ready = 1'b0; bus.EXEC_done = 1'b0; bus.FLAG_Z = 1'b0; bus.MEM_rdata = 8'h00;
        pc = pc0;
        bus.PC_cur = pc0;
        #1;
        chk("rst_ir",     bus.IR,         8'h00);
        chk("rst_load",   bus.PC_load,    1'b0);
        chk("rst_tgt",    bus.PC_target,  8'h00);
        chk("rst_start",  bus.EXEC_start, 1'b0);
        chk("rst_halted", bus.HALTED,     1'b0);
        chk("rst_req",    bus.MEM_req,    1'b1);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        logic [7:0] s;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        bus.PC_cur = 8'h00; bus.MEM_rdata = 8'h00; bus.MEM_ready = 1'b0;
        bus.EXEC_done = 1'b0; bus.FLAG_Z = 1'b0;
        pc = 8'h00;
        #2;

        // exec op at 00, done two cycles after start
        mem[8'h00] = 8'h05;
        do_reset(8'h00);
        gen(8'h00, 1, 0, -1, 1);
        run_rows(1000);
        chk("t1_pc", pc, 8'h01);
        chk("t1_model_pc", m_pc, 8'h01);
        chk("t1_ir", bus.IR, 8'h05);
        bus.MEM_ready = 1'b0;
        @(negedge CLK);
        chk("t1_back_fetch", bus.MEM_req, 1'b1);
        @(posedge CLK);
        #1;

        // JMP 10 -> 40
        mem[8'h10] = 8'hC0; mem[8'h11] = 8'h40;
        do_reset(8'h10);
        gen(8'h10, 1, 0, -1, -1);
        chk("t2_rows", rows.size(), 5);
        run_rows(1000);
        chk("t2_pc", pc, 8'h40);

        // JZ not taken / taken
        mem[8'h20] = 8'hE0; mem[8'h21] = 8'h80;
        do_reset(8'h20);
        gen(8'h20, 1, 0, 0, -1);
        chk("t3_nt_rows", rows.size(), 3);
        run_rows(1000);
        chk("t3_nt_pc", pc, 8'h22);
        do_reset(8'h20);
        gen(8'h20, 1, 0, 1, -1);
        run_rows(1000);
        chk("t3_tk_pc", pc, 8'h80);

        // operand fetch wraps from FF to 00
        mem[8'hFF] = 8'hC0; mem[8'h00] = 8'h07;
        do_reset(8'hFF);
        gen(8'hFF, 1, 0, -1, -1);
        run_rows(1000);
        chk("t4_pc", pc, 8'h07);

        // three-cycle memory wait on both fetch and operand
        mem[8'h60] = 8'hC5; mem[8'h61] = 8'h70; mem[8'h70] = 8'h12;
        do_reset(8'h60);
        gen(8'h60, 2, 3, -1, 2);
        run_rows(1000);
        chk("t5_pc", pc, 8'h71);

        // HALT, then a reset in the middle of an execute
        mem[8'h30] = 8'h3F;
        do_reset(8'h30);
        gen(8'h30, 1, 0, -1, -1);
        run_rows(1000);
        chk("t6_halted", bus.HALTED, 1'b1);
        chk("t6_req", bus.MEM_req, 1'b0);
        mem[8'h40] = 8'h05;
        do_reset(8'h40);
        gen(8'h40, 1, 0, -1, 6);
        run_rows(5);
        chk("t6_in_exec", bus.EXEC_start, 1'b0);
        mem[8'h50] = 8'h11; mem[8'h51] = 8'h3F;
        do_reset(8'h50);
        gen(8'h50, 2, 0, -1, -1);
        run_rows(1000);
        chk("t6_halt2", bus.HALTED, 1'b1);

        // random programs with random waits, flags and exec latencies
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            s = 8'($urandom);
            do_reset(s);
            gen(s, 25, -1, -1, -1);
            run_rows(100000);
            chk($sformatf("rnd%0d_pc", p), pc, m_pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
